spdif_tx: RTL and testbench

- Consumes stereo PCM pairs from the audio engine and emits an IEC 60958 consumer-format S/PDIF biphase-mark (BMC) stream on a single pin.
- Sits directly downstream of the audio engine's sample path and drives the board S/PDIF output.
- Contains its own frame, subframe and block sequencing, plus channel-status, parity and preamble generation.
- Has a one-deep input holding register with a valid/ready handshake.

---
 rtl/spdif_tx.sv | 159 +++++++++++++++
 tb/tb_spdif_tx.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spdif_tx.sv
// IEC 60958 consumer S/PDIF transmitter: stereo PCM in, biphase-mark line out.
// Holds one pending pair; frames, subframes and 192-frame blocks are sequenced here.
module spdif_tx #(
    parameter int          DATA_WIDTH = 24,
    parameter int          CLK_DIV    = 4,
    parameter logic [31:0] CS_WORD    = 32'h0000_0004
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic [DATA_WIDTH-1:0] left_i,
    input  logic [DATA_WIDTH-1:0] right_i,
    input  logic                  sample_valid_i,
    output logic                  sample_ready_o,
    output logic                  spdif_o,
    output logic                  block_start_o,
    output logic                  underrun_o
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int PAD   = 24 - DATA_WIDTH;
    localparam logic [7:0] PRE_B = 8'b1110_1000;
    localparam logic [7:0] PRE_M = 8'b1110_0010;
    localparam logic [7:0] PRE_W = 8'b1110_0100;

    logic [DIV_W-1:0]      div_q, div_d;
    logic [6:0]            hb_q, hb_d;
    logic [7:0]            frame_q, frame_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
    logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
    logic [DATA_WIDTH-1:0] tx_l_q, tx_l_d;
    logic [DATA_WIDTH-1:0] tx_r_q, tx_r_d;
    logic                  spdif_q, spdif_d;
    logic                  pol_q, pol_d;
    logic                  block_start_q, block_start_d;
    logic                  underrun_q, underrun_d;

    logic                  tick;
    logic                  frame_start;
    logic                  accept;
    logic                  half;
    logic [4:0]            slot;
    logic                  sub;
    logic [4:0]            fidx;
    logic [2:0]            pidx;
    logic [DATA_WIDTH-1:0] sample;
    logic [23:0]           field;
    logic [7:0]            pre;
    logic                  c_bit;
    logic                  par;
    logic                  pol;
    logic                  data_bit;

    always_comb begin
        tick        = (div_q == '0);
        div_d       = tick ? DIV_W'(CLK_DIV - 1) : div_q - DIV_W'(1);
        half        = hb_q[0];
        slot        = hb_q[5:1];
        sub         = hb_q[6];
        fidx        = slot - 5'd4;
        pidx        = {slot[1:0], half};
        frame_start = tick && (hb_q == 7'd0);
        accept      = sample_valid_i && !hold_full_q;

        sample = sub ? tx_r_q : tx_l_q;
        field  = 24'(sample) << PAD;
        c_bit  = (frame_q < 8'd32) ? CS_WORD[frame_q[4:0]] : 1'b0;
        par    = (^field) ^ c_bit;
        pre    = sub ? PRE_W : ((frame_q == 8'd0) ? PRE_B : PRE_M);

        // Preamble polarity follows the line level left by the previous subframe
        pol = (slot == 5'd0 && !half) ? spdif_q : pol_q;

        unique case (1'b1)
            (slot >= 5'd4 && slot <= 5'd27): data_bit = field[fidx];
            (slot == 5'd30):                 data_bit = c_bit;
            (slot == 5'd31):                 data_bit = par;
            default:                         data_bit = 1'b0;
        endcase

        hb_d          = hb_q;
        frame_d       = frame_q;
        spdif_d       = spdif_q;
        pol_d         = pol_q;
        hold_full_d   = hold_full_q;
        hold_l_d      = hold_l_q;
        hold_r_d      = hold_r_q;
        tx_l_d        = tx_l_q;
        tx_r_d        = tx_r_q;
        block_start_d = 1'b0;
        underrun_d    = 1'b0;

        if (tick) begin
            hb_d  = hb_q + 7'd1;
            pol_d = pol;
            if (hb_q == 7'd127) begin
                frame_d = (frame_q == 8'd191) ? 8'd0 : frame_q + 8'd1;
            end
            if (slot < 5'd4) begin
                spdif_d = pre[3'd7 - pidx] ^ pol;
            end else if (!half) begin
                spdif_d = !spdif_q;
            end else begin
                spdif_d = spdif_q ^ data_bit;
            end
        end

        if (frame_start) begin
            block_start_d = (frame_q == 8'd0);
            underrun_d    = !hold_full_q;
            tx_l_d        = hold_full_q ? hold_l_q : '0;
            tx_r_d        = hold_full_q ? hold_r_q : '0;
            hold_full_d   = 1'b0;
        end

        // Accept only happens when empty, so it never collides with a load
        if (accept) begin
            hold_l_d    = left_i;
            hold_r_d    = right_i;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            div_q         <= '0;
            hb_q          <= '0;
            frame_q       <= '0;
            hold_full_q   <= 1'b0;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            tx_l_q        <= '0;
            tx_r_q        <= '0;
            spdif_q       <= 1'b0;
            pol_q         <= 1'b0;
            block_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            div_q         <= div_d;
            hb_q          <= hb_d;
            frame_q       <= frame_d;
            hold_full_q   <= hold_full_d;
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
            tx_l_q        <= tx_l_d;
            tx_r_q        <= tx_r_d;
            spdif_q       <= spdif_d;
            pol_q         <= pol_d;
            block_start_q <= block_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign sample_ready_o = !hold_full_q;
    assign spdif_o        = spdif_q;
    assign block_start_o  = block_start_q;
    assign underrun_o     = underrun_q;

endmodule

// File: tb/tb_spdif_tx.sv
// Bench for spdif_tx: frames are captured half-bit by half-bit and compared
// against a reference built from the IEC 60958 subframe rules.
module tb_spdif_tx;

    localparam logic [31:0] CS = 32'h0000_0004;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        srst;
    logic [23:0] left, right;
    logic        valid;
    logic        ready, spdif, bs, ur;
    logic [15:0] left16, right16;
    logic        valid16;
    logic        ready16, spdif16, bs16, ur16;

    spdif_tx #(.DATA_WIDTH(24), .CLK_DIV(2), .CS_WORD(CS)) u_dut (
        .clk_i(clk), .srst_i(srst), .left_i(left), .right_i(right),
        .sample_valid_i(valid), .sample_ready_o(ready), .spdif_o(spdif),
        .block_start_o(bs), .underrun_o(ur)
    );

    spdif_tx #(.DATA_WIDTH(16), .CLK_DIV(2), .CS_WORD(CS)) u_dut16 (
        .clk_i(clk), .srst_i(srst), .left_i(left16), .right_i(right16),
        .sample_valid_i(valid16), .sample_ready_o(ready16), .spdif_o(spdif16),
        .block_start_o(bs16), .underrun_o(ur16)
    );

    logic sel;
    logic mon_spdif, mon_rdy, mon_bs, mon_ur;
    assign mon_spdif = sel ? spdif16 : spdif;
    assign mon_rdy   = sel ? ready16 : ready;
    assign mon_bs    = sel ? bs16 : bs;
    assign mon_ur    = sel ? ur16 : ur;

    int errors = 0;
    int checks = 0;

    logic         lvl;
    logic [127:0] obs, exp_hb;
    int           ur_n, ur_at, bs_n, bs_at, rdy_n;
    logic         hs_on;
    logic [23:0]  hs_cnt;

    task automatic do_reset();
        @(negedge clk);
        srst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        srst = 1'b0;
    endtask

    task automatic get_frame(output logic [127:0] hb, output int urn,
                             output int urat, output int bsn,
                             output int bsat, output int rdyn);
        urn = 0; urat = -1; bsn = 0; bsat = -1; rdyn = 0; hb = '0;
        for (int k = 0; k < 128; k++) begin
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                if (c == 0) hb[k] = mon_spdif;
                if (mon_ur) begin
                    urn++;
                    if (urat < 0) urat = 2 * k + c;
                end
                if (mon_bs) begin
                    bsn++;
                    if (bsat < 0) bsat = 2 * k + c;
                end
                if (mon_rdy) rdyn++;
            end
        end
    endtask

    // Reference: build 32 slot bits per subframe, then biphase-mark encode.
    task automatic model_frame(input int fi, input logic [23:0] l,
                               input logic [23:0] r, inout logic lv,
                               output logic [127:0] hb);
        logic [7:0]  pat;
        logic [23:0] f;
        logic        b, c;
        int          ones, base;
        hb = '0;
        c = 1'b0;
        if (fi < 32) c = CS[fi];
        for (int sb = 0; sb < 2; sb++) begin
            base = sb * 64;
            if (sb == 1)       pat = 8'b1110_0100;
            else if (fi == 0)  pat = 8'b1110_1000;
            else               pat = 8'b1110_0010;
            f = (sb == 1) ? r : l;
            for (int k = 0; k < 8; k++) hb[base + k] = pat[7 - k] ^ lv;
            lv = hb[base + 7];
            ones = 0;
            for (int s = 4; s < 32; s++) begin
                if (s <= 27)      b = f[s - 4];
                else if (s == 30) b = c;
                else if (s == 31) b = ones[0];
                else              b = 1'b0;
                ones += int'(b);
                lv = ~lv;
                hb[base + 2 * s] = lv;
                if (b) lv = ~lv;
                hb[base + 2 * s + 1] = lv;
            end
        end
    endtask

    function automatic logic sbit(input logic [127:0] hb, input int sb,
                                  input int s);
        return hb[sb * 64 + 2 * s] ^ hb[sb * 64 + 2 * s + 1];
    endfunction

    function automatic logic [23:0] audio(input logic [127:0] hb,
                                          input int sb);
        logic [23:0] a;
        for (int i = 0; i < 24; i++) a[i] = sbit(hb, sb, 4 + i);
        return a;
    endfunction

    task automatic hs_driver();
        logic pend;
        pend = mon_rdy;
        while (hs_on) begin
            @(negedge clk);
            if (pend) hs_cnt = hs_cnt + 24'd1;
            left  = hs_cnt;
            right = ~hs_cnt;
            pend  = ready;
        end
        valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        srst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (spdif !== 1'b0) begin
            errors++; $display("FAIL rst_spdif got=%b want=0", spdif);
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL rst_ready got=%b want=1", ready);
        end
        checks++;
        if (bs !== 1'b0) begin
            errors++; $display("FAIL rst_bs got=%b want=0", bs);
        end
        checks++;
        if (ur !== 1'b0) begin
            errors++; $display("FAIL rst_ur got=%b want=0", ur);
        end
        srst = 1'b0;
    endtask

    task automatic test_idle();
        logic [7:0] o8;
        get_frame(obs, ur_n, ur_at, bs_n, bs_at, rdy_n);
        for (int i = 0; i < 8; i++) o8[7 - i] = obs[i];
        checks++;
        if (o8 !== 8'b1110_1000) begin
            errors++; $display("FAIL idle_pre_b got=%b want=11101000", o8);
        end
        lvl = 1'b0;
        model_frame(0, 24'd0, 24'd0, lvl, exp_hb);
        checks++;
        if (obs !== exp_hb) begin
            errors++; $display("FAIL idle_frame got=%h want=%h", obs, exp_hb);
        end
        checks++;
        if (ur_n !== 1 || ur_at !== 0) begin
            errors++; $display("FAIL idle_ur got=%0d@%0d want=1@0", ur_n, ur_at);
        end
        checks++;
        if (bs_n !== 1 || bs_at !== 0) begin
            errors++; $display("FAIL idle_bs got=%0d@%0d want=1@0", bs_n, bs_at);
        end
        checks++;
        if (sbit(obs, 0, 31) !== 1'b0 || sbit(obs, 1, 31) !== 1'b0) begin
            errors++; $display("FAIL idle_par got=%b%b want=00",
                               sbit(obs, 0, 31), sbit(obs, 1, 31));
        end
    endtask

    task automatic test_data_path();
        sel = 1'b0;
        left = 24'h800001; right = 24'h7FFFFF; valid = 1'b1;
        do_reset();
        fork begin @(negedge clk); valid = 1'b0; end join_none
        lvl = 1'b0;
        for (int f = 0; f < 3; f++) begin
            get_frame(obs, ur_n, ur_at, bs_n, bs_at, rdy_n);
            if (f == 1) model_frame(f, 24'h800001, 24'h7FFFFF, lvl, exp_hb);
            else        model_frame(f, 24'd0, 24'd0, lvl, exp_hb);
            checks++;
            if (obs !== exp_hb) begin
                errors++; $display("FAIL dp_frame%0d got=%h want=%h", f, obs, exp_hb);
            end
            checks++;
            if (ur_n !== ((f == 1) ? 0 : 1)) begin
                errors++; $display("FAIL dp_ur%0d got=%0d want=%0d",
                                   f, ur_n, (f == 1) ? 0 : 1);
            end
            if (f == 1) begin
                checks++;
                if (audio(obs, 0) !== 24'h800001) begin
                    errors++; $display("FAIL dp_left got=%h want=800001", audio(obs, 0));
                end
                checks++;
                if (audio(obs, 1) !== 24'h7FFFFF) begin
                    errors++; $display("FAIL dp_right got=%h want=7fffff", audio(obs, 1));
                end
                checks++;
                if (sbit(obs, 0, 31) !== 1'b0 || sbit(obs, 1, 31) !== 1'b1) begin
                    errors++; $display("FAIL dp_par got=%b%b want=01",
                                       sbit(obs, 0, 31), sbit(obs, 1, 31));
                end
            end
            if (f == 2) begin
                checks++;
                if (audio(obs, 0) !== 24'd0 || audio(obs, 1) !== 24'd0) begin
                    errors++; $display("FAIL dp_zero got=%h/%h want=0/0",
                                       audio(obs, 0), audio(obs, 1));
                end
            end
        end
    endtask

    task automatic test_handshake();
        logic [23:0] el, er;
        sel = 1'b0;
        hs_cnt = 24'd0;
        left = 24'd0; right = ~24'd0; valid = 1'b1;
        do_reset();
        hs_on = 1'b1;
        fork hs_driver(); join_none
        lvl = 1'b0;
        for (int f = 0; f < 6; f++) begin
            get_frame(obs, ur_n, ur_at, bs_n, bs_at, rdy_n);
            el = (f == 0) ? 24'd0 : 24'(f - 1);
            er = (f == 0) ? 24'd0 : ~24'(f - 1);
            model_frame(f, el, er, lvl, exp_hb);
            checks++;
            if (obs !== exp_hb) begin
                errors++; $display("FAIL hs_frame%0d got=%h want=%h", f, obs, exp_hb);
            end
            checks++;
            if (rdy_n !== ((f == 0) ? 0 : 1)) begin
                errors++; $display("FAIL hs_ready%0d got=%0d want=%0d",
                                   f, rdy_n, (f == 0) ? 0 : 1);
            end
            checks++;
            if (ur_n !== ((f == 0) ? 1 : 0)) begin
                errors++; $display("FAIL hs_ur%0d got=%0d want=%0d",
                                   f, ur_n, (f == 0) ? 1 : 0);
            end
        end
        hs_on = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_dw16();
        sel = 1'b1;
        left16 = 16'h8000; right16 = 16'h0001; valid16 = 1'b1;
        do_reset();
        fork begin @(negedge clk); valid16 = 1'b0; end join_none
        lvl = 1'b0;
        get_frame(obs, ur_n, ur_at, bs_n, bs_at, rdy_n);
        model_frame(0, 24'd0, 24'd0, lvl, exp_hb);
        get_frame(obs, ur_n, ur_at, bs_n, bs_at, rdy_n);
        model_frame(1, 24'h800000, 24'h000100, lvl, exp_hb);
        checks++;
        if (obs !== exp_hb) begin
            errors++; $display("FAIL dw16_frame got=%h want=%h", obs, exp_hb);
        end
        checks++;
        if (audio(obs, 0) !== 24'h800000) begin
            errors++; $display("FAIL dw16_left got=%h want=800000", audio(obs, 0));
        end
        checks++;
        if (audio(obs, 1) !== 24'h000100) begin
            errors++; $display("FAIL dw16_right got=%h want=000100", audio(obs, 1));
        end
        sel = 1'b0;
    endtask

    task automatic test_mid_reset();
        sel = 1'b0;
        valid = 1'b0;
        do_reset();
        get_frame(obs, ur_n, ur_at, bs_n, bs_at, rdy_n);
        @(negedge clk);
        left = $urandom(); right = $urandom(); valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (194) @(negedge clk);
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL mid_full got=%b want=0", ready);
        end
        srst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || spdif !== 1'b0) begin
            errors++; $display("FAIL mid_rst got=%b%b want=10", ready, spdif);
        end
        srst = 1'b0;
        lvl = 1'b0;
        for (int f = 0; f < 2; f++) begin
            get_frame(obs, ur_n, ur_at, bs_n, bs_at, rdy_n);
            model_frame(f, 24'd0, 24'd0, lvl, exp_hb);
            checks++;
            if (obs !== exp_hb) begin
                errors++; $display("FAIL mid_frame%0d got=%h want=%h", f, obs, exp_hb);
            end
            checks++;
            if (bs_n !== ((f == 0) ? 1 : 0) || ur_n !== 1) begin
                errors++; $display("FAIL mid_pulse%0d got=bs%0d ur%0d", f, bs_n, ur_n);
            end
        end
    endtask

    task automatic test_channel_status();
        int fi;
        logic ec;
        sel = 1'b0;
        valid = 1'b0;
        do_reset();
        lvl = 1'b0;
        for (int f = 0; f < 196; f++) begin
            fi = f % 192;
            get_frame(obs, ur_n, ur_at, bs_n, bs_at, rdy_n);
            model_frame(fi, 24'd0, 24'd0, lvl, exp_hb);
            checks++;
            if (obs !== exp_hb) begin
                errors++; $display("FAIL cs_frame%0d got=%h want=%h", f, obs, exp_hb);
            end
            ec = (fi == 2);
            checks++;
            if (sbit(obs, 0, 30) !== ec || sbit(obs, 1, 30) !== ec) begin
                errors++; $display("FAIL cs_c%0d got=%b%b want=%b%b", f,
                                   sbit(obs, 0, 30), sbit(obs, 1, 30), ec, ec);
            end
            checks++;
            if (bs_n !== ((fi == 0) ? 1 : 0)) begin
                errors++; $display("FAIL cs_bs%0d got=%0d want=%0d",
                                   f, bs_n, (fi == 0) ? 1 : 0);
            end
            checks++;
            if (ur_n !== 1 || ur_at !== 0) begin
                errors++; $display("FAIL cs_ur%0d got=%0d@%0d want=1@0",
                                   f, ur_n, ur_at);
            end
        end
    endtask

    initial begin
        sel = 1'b0; srst = 1'b0; hs_on = 1'b0; hs_cnt = 24'd0;
        left = '0; right = '0; valid = 1'b0;
        left16 = '0; right16 = '0; valid16 = 1'b0;
        test_reset();
        test_idle();
        test_data_path();
        test_handshake();
        test_dw16();
        test_mid_reset();
        test_channel_status();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
